// File: rtl/if_bht.sv
`default_nettype none
// ============================================================================
// Module   : if_bht
// Brief    : Instruction-fetch stage with a 2-bit saturating-counter BHT,
//            static JAL redirect and IF/ID pipeline registers.
// Revision : 1.0 - initial release
// ============================================================================
module if_bht #(
    parameter int          ENTRIES  = 16,
    parameter logic [1:0]  CTR_INIT = 2'b01,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    output logic        ICACHE_ren,
    output logic        ICACHE_wen,
    output logic [29:0] ICACHE_addr,
    output logic [31:0] ICACHE_wdata,
    input  logic [31:0] ICACHE_rdata,
    input  logic        pc_sel,
    input  logic [31:0] pc_jump,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    output logic [31:0] pc_if,
    output logic [31:0] pc_4_if,
    output logic [31:0] instr_if,
    output logic        BrPre_if
);

    localparam int IDX_W = $clog2(ENTRIES);

    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;

    logic [31:0]      r_pc;
    logic [31:0]      r_pc_if;
    logic [31:0]      r_pc_4_if;
    logic [31:0]      r_instr_if;
    logic             r_br_pre_if;
    logic [1:0]       r_ctr [ENTRIES];

    logic [31:0]      w_instr;
    logic             w_is_b;
    logic             w_is_j;
    logic [IDX_W-1:0] w_rd_idx;
    logic [IDX_W-1:0] w_upd_idx;
    logic [1:0]       w_ctr_rd;
    logic [1:0]       w_ctr_old;
    logic [1:0]       w_ctr_new;
    logic             w_br_pre;
    logic             w_pred;
    logic [31:0]      w_imm_b;
    logic [31:0]      w_imm_j;
    logic [31:0]      w_pc_4;
    logic [31:0]      w_pc_next;
    logic             w_unused_upd;

    assign ICACHE_ren   = 1'b1;
    assign ICACHE_wen   = 1'b0;
    assign ICACHE_wdata = 32'h0000_0000;
    assign ICACHE_addr  = r_pc[31:2];

    // The memory returns words little-endian; instructions are decoded big-endian.
    assign w_instr = {ICACHE_rdata[7:0], ICACHE_rdata[15:8],
                      ICACHE_rdata[23:16], ICACHE_rdata[31:24]};

    assign w_is_b = (w_instr[6:0] == c_OP_BRANCH);
    assign w_is_j = (w_instr[6:0] == c_OP_JAL);

    // Tag-less table: upper PC bits are dropped, aliasing is accepted.
    assign w_rd_idx     = r_pc[IDX_W+1:2];
    assign w_upd_idx    = upd_pc[IDX_W+1:2];
    assign w_unused_upd = ^{upd_pc[31:IDX_W+2], upd_pc[1:0]};

    assign w_ctr_rd = r_ctr[w_rd_idx];
    assign w_br_pre = w_is_b & w_ctr_rd[1];
    assign w_pred   = w_br_pre | w_is_j;

    assign w_imm_b = {{19{w_instr[31]}}, w_instr[31], w_instr[7],
                      w_instr[30:25], w_instr[11:8], 1'b0};
    assign w_imm_j = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12],
                      w_instr[20], w_instr[30:21], 1'b0};

    assign w_pc_4 = r_pc + 32'd4;

    always_comb begin
        w_pc_next = w_pc_4;
        if (pc_sel) begin
            w_pc_next = pc_jump;
        end else if (w_is_j) begin
            w_pc_next = r_pc + w_imm_j;
        end else if (w_br_pre) begin
            w_pc_next = r_pc + w_imm_b;
        end
    end

    assign w_ctr_old = r_ctr[w_upd_idx];

    always_comb begin
        w_ctr_new = w_ctr_old;
        if (upd_taken) begin
            if (w_ctr_old != 2'b11) begin
                w_ctr_new = w_ctr_old + 2'd1;
            end
        end else begin
            if (w_ctr_old != 2'b00) begin
                w_ctr_new = w_ctr_old - 2'd1;
            end
        end
    end

    // Counters train independently of stall/flush; reads see the pre-update value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_ctr[i] <= CTR_INIT;
            end
        end else if (upd_valid) begin
            r_ctr[w_upd_idx] <= w_ctr_new;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            r_pc_if     <= 32'h0000_0000;
            r_pc_4_if   <= 32'h0000_0000;
            r_instr_if  <= 32'h0000_0000;
            r_br_pre_if <= 1'b0;
        end else if (!stall) begin
            r_pc        <= w_pc_next;
            r_pc_if     <= r_pc;
            r_pc_4_if   <= w_pc_4;
            r_instr_if  <= pc_sel ? 32'h0000_0000 : w_instr;
            r_br_pre_if <= pc_sel ? 1'b0 : w_pred;
        end
    end

    assign pc_if    = r_pc_if;
    assign pc_4_if  = r_pc_4_if;
    assign instr_if = r_instr_if;
    assign BrPre_if = r_br_pre_if;

endmodule
`default_nettype wire

// File: tb/tb_if_bht.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_bht
// Brief    : Directed bench for if_bht (16- and 4-entry instances) against
//            a behavioural fetch/predictor model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_bht;

    localparam logic [31:0] c_NOP  = 32'h0000_0013;  // addi x0,x0,0
    localparam logic [31:0] c_BEQ  = 32'h0000_0863;  // beq x0,x0,+16
    localparam logic [31:0] c_JAL  = 32'hFF9F_F06F;  // jal x0,-8

    logic        clk;
    logic        rst;
    logic        stall;
    logic [31:0] rdata;
    logic        pc_sel;
    logic [31:0] pc_jump;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;

    logic        ren16, wen16, bp16, ren4, wen4, bp4;
    logic [29:0] addr16, addr4;
    logic [31:0] wd16, pcif16, pc4if16, insif16, wd4, pcif4, pc4if4, insif4;

    int n_err = 0;
    int n_chk = 0;

    if_bht #(.ENTRIES(16)) dut16 (
        .clk(clk), .rst(rst), .stall(stall),
        .ICACHE_ren(ren16), .ICACHE_wen(wen16), .ICACHE_addr(addr16),
        .ICACHE_wdata(wd16), .ICACHE_rdata(rdata),
        .pc_sel(pc_sel), .pc_jump(pc_jump),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .pc_if(pcif16), .pc_4_if(pc4if16), .instr_if(insif16), .BrPre_if(bp16)
    );

    if_bht #(.ENTRIES(4)) dut4 (
        .clk(clk), .rst(rst), .stall(stall),
        .ICACHE_ren(ren4), .ICACHE_wen(wen4), .ICACHE_addr(addr4),
        .ICACHE_wdata(wd4), .ICACHE_rdata(rdata),
        .pc_sel(pc_sel), .pc_jump(pc_jump),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .pc_if(pcif4), .pc_4_if(pc4if4), .instr_if(insif4), .BrPre_if(bp4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic int ents(input int k);
        return (k == 0) ? 16 : 4;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: index 0 = 16 entries, 1 = 4 entries
    logic [31:0] m_pc    [2];
    logic [31:0] m_pcif  [2];
    logic [31:0] m_pc4   [2];
    logic [31:0] m_insif [2];
    logic        m_bpif  [2];
    int          m_ctr   [2][256];
    logic [31:0] m_nxt   [2];
    logic        m_pred  [2];
    int          m_cnew  [2];
    logic [31:0] m_ins;

    always_comb begin
        int   bi;
        int   ji;
        int   c;
        logic is_b;
        logic is_j;
        logic taken;
        m_ins = swap(rdata);
        is_b  = (m_ins[6:0] == 7'h63);
        is_j  = (m_ins[6:0] == 7'h6F);
        bi = int'(m_ins[7]) * 2048 + int'(m_ins[30:25]) * 32 + int'(m_ins[11:8]) * 2
             - (m_ins[31] ? 4096 : 0);
        ji = int'(m_ins[19:12]) * 4096 + int'(m_ins[20]) * 2048 + int'(m_ins[30:21]) * 2
             - (m_ins[31] ? 1048576 : 0);
        for (int k = 0; k < 2; k++) begin
            taken = is_b && (m_ctr[k][int'(m_pc[k] >> 2) % ents(k)] >= 2);
            m_pred[k] = taken || is_j;
            if (pc_sel)      m_nxt[k] = pc_jump;
            else if (is_j)   m_nxt[k] = m_pc[k] + 32'(ji);
            else if (taken)  m_nxt[k] = m_pc[k] + 32'(bi);
            else             m_nxt[k] = m_pc[k] + 32'd4;
            c = m_ctr[k][int'(upd_pc >> 2) % ents(k)];
            m_cnew[k] = upd_taken ? ((c == 3) ? 3 : c + 1) : ((c == 0) ? 0 : c - 1);
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                m_pc[k]    <= 32'h0;
                m_pcif[k]  <= 32'h0;
                m_pc4[k]   <= 32'h0;
                m_insif[k] <= 32'h0;
                m_bpif[k]  <= 1'b0;
                for (int i = 0; i < 256; i++) m_ctr[k][i] <= 1;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (upd_valid) m_ctr[k][int'(upd_pc >> 2) % ents(k)] <= m_cnew[k];
                if (!stall) begin
                    m_pc[k]    <= m_nxt[k];
                    m_pcif[k]  <= m_pc[k];
                    m_pc4[k]   <= m_pc[k] + 32'd4;
                    m_insif[k] <= pc_sel ? 32'h0 : m_ins;
                    m_bpif[k]  <= pc_sel ? 1'b0 : m_pred[k];
                end
            end
        end
    end

    // ---------------- per-cycle comparison against the model
    always @(negedge clk) begin
        chk("m16_addr",  {2'b00, addr16}, {2'b00, m_pc[0][31:2]});
        chk("m16_pcif",  pcif16,  m_pcif[0]);
        chk("m16_pc4if", pc4if16, m_pc4[0]);
        chk("m16_insif", insif16, m_insif[0]);
        chk("m16_bpif",  {31'h0, bp16}, {31'h0, m_bpif[0]});
        chk("m4_addr",   {2'b00, addr4}, {2'b00, m_pc[1][31:2]});
        chk("m4_pcif",   pcif4,   m_pcif[1]);
        chk("m4_pc4if",  pc4if4,  m_pc4[1]);
        chk("m4_insif",  insif4,  m_insif[1]);
        chk("m4_bpif",   {31'h0, bp4}, {31'h0, m_bpif[1]});
        chk("const_if",  {wd16, ren16, wen16, ren4, wen4},
                         {32'h0, 1'b1, 1'b0, 1'b1, 1'b0});
    end

    // ---------------- stimulus with hand-computed literal expectations
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic jump(input logic [31:0] a);
        pc_sel  = 1'b1;
        pc_jump = a;
        rdata   = swap(c_NOP);
        cyc(1);
        pc_sel  = 1'b0;
    endtask

    task automatic upd(input logic [31:0] a, input logic t, input int n);
        upd_valid = 1'b1;
        upd_pc    = a;
        upd_taken = t;
        cyc(n);
        upd_valid = 1'b0;
    endtask

    task automatic fetch_one(input logic [31:0] ins);
        rdata = swap(ins);
        cyc(1);
        rdata = swap(c_NOP);
    endtask

    task automatic chk_addr(input string name, input logic [31:0] e16, input logic [31:0] e4);
        chk({name, "_16"}, {addr16, 2'b00}, e16);
        chk({name, "_4"},  {addr4, 2'b00},  e4);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; rdata = swap(c_NOP);
        pc_sel = 1'b0; pc_jump = 32'h0;
        upd_valid = 1'b0; upd_pc = 32'h0; upd_taken = 1'b0;
        cyc(2);
        chk("rst_pcif", pcif16, 32'h0);
        chk("rst_insif", insif16, 32'h0);
        rst = 1'b0;
        chk_addr("seq0", 32'h0, 32'h0);
        cyc(1);
        chk_addr("seq1", 32'h4, 32'h4);
        cyc(1);
        chk_addr("seq2", 32'h8, 32'h8);
        chk("seq_insif", insif16, c_NOP);
        chk("seq_bp", {31'h0, bp16}, 32'h0);

        // trained branch at 0x40 predicts taken to 0x50
        upd(32'h40, 1'b1, 2);
        jump(32'h40);
        fetch_one(c_BEQ);
        chk_addr("beq_taken", 32'h50, 32'h50);
        chk("beq_bp", {31'h0, bp16}, 32'h1);
        chk("beq_pcif", pcif16, 32'h40);

        // saturation: 5T+1NT -> 10 (taken), 3NT more -> 00 (not taken)
        upd(32'h44, 1'b1, 5);
        upd(32'h44, 1'b0, 1);
        jump(32'h44);
        fetch_one(c_BEQ);
        chk_addr("sat_10", 32'h54, 32'h54);
        upd(32'h44, 1'b0, 3);
        jump(32'h44);
        fetch_one(c_BEQ);
        chk_addr("sat_00", 32'h48, 32'h48);
        chk("sat_bp", {31'h0, bp16}, 32'h0);

        // JAL -8 at 0x100
        jump(32'h100);
        fetch_one(c_JAL);
        chk_addr("jal", 32'hF8, 32'hF8);
        chk("jal_bp", {31'h0, bp16}, 32'h1);
        chk("jal_pc4if", pc4if16, 32'h104);

        // redirect beats prediction, then stall beats redirect
        jump(32'h40);
        rdata = swap(c_BEQ); pc_sel = 1'b1; pc_jump = 32'h200;
        cyc(1);
        chk_addr("flush", 32'h200, 32'h200);
        chk("flush_ins", insif16, 32'h0);
        chk("flush_bp", {31'h0, bp16}, 32'h0);
        stall = 1'b1; pc_jump = 32'h300;
        upd_valid = 1'b1; upd_pc = 32'h48; upd_taken = 1'b1;
        cyc(1);
        stall = 1'b0; pc_sel = 1'b0; upd_valid = 1'b0; rdata = swap(c_NOP);
        chk_addr("stall", 32'h200, 32'h200);
        chk("stall_pcif", pcif16, 32'h40);
        jump(32'h48);
        fetch_one(c_BEQ);
        chk_addr("stall_upd", 32'h58, 32'h58);

        // asynchronous reset with an update pending
        upd_valid = 1'b1; upd_pc = 32'h30; upd_taken = 1'b1;
        #1 rst = 1'b1;
        #1;
        chk_addr("arst", 32'h0, 32'h0);
        chk("arst_pcif", pcif16, 32'h0);
        upd_valid = 1'b0;
        cyc(1);
        rst = 1'b0;

        // aliasing: 0x10 and 0x20 share an entry only in the 4-entry table
        upd(32'h10, 1'b1, 1);
        upd(32'h20, 1'b0, 2);
        jump(32'h10);
        fetch_one(c_BEQ);
        chk_addr("alias", 32'h20, 32'h14);
        upd(32'h20, 1'b1, 1);
        jump(32'h30);
        upd_valid = 1'b1; upd_pc = 32'h30; upd_taken = 1'b1;
        fetch_one(c_BEQ);
        upd_valid = 1'b0;
        chk_addr("nobypass", 32'h34, 32'h34);
        jump(32'h30);
        fetch_one(c_BEQ);
        chk_addr("after_upd", 32'h40, 32'h40);

        // reset restores every counter to weakly not-taken
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        jump(32'h30);
        fetch_one(c_BEQ);
        chk_addr("rst_ctr", 32'h34, 32'h34);
        jump(32'h40);
        fetch_one(c_BEQ);
        chk_addr("rst_ctr40", 32'h44, 32'h44);

        cyc(2);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_bht.md
IF_BHT -- requirements
Module: if_bht

Interface
REQ-001 SHALL have parameter ENTRIES, default 16: BHT entry count; power of two, 2..256.
REQ-002 SHALL have parameter CTR_INIT, default 2'b01: reset value of every 2-bit counter (weakly not-taken).
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000: fetch PC after reset.
REQ-004 SHALL derive IDX_W = log2(ENTRIES) internally; it SHALL NOT be a port.
REQ-005 clk  in  1  the block's only clock; all state on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 stall  in  1  hold all fetch state and IF/ID registers.
REQ-008 ICACHE_ren  out  1  constant 1.
REQ-009 ICACHE_wen  out  1  constant 0.
REQ-010 ICACHE_addr  out  30  word address, pc_r[31:2].
REQ-011 ICACHE_wdata  out  32  constant 0.
REQ-012 ICACHE_rdata  in  32  fetched word, byte-swapped relative to the instruction.
REQ-013 pc_sel  in  1  redirect from a later stage; also flushes IF/ID.
REQ-014 pc_jump  in  32  redirect target.
REQ-015 upd_valid  in  1  branch resolution strobe, one cycle per resolved conditional branch.
REQ-016 upd_pc  in  32  PC of the resolved branch.
REQ-017 upd_taken  in  1  actual outcome of the resolved branch.
REQ-018 pc_if, pc_4_if, instr_if  out  32 each  IF/ID PC, PC+4 and instruction.
REQ-019 BrPre_if  out  1  IF/ID flag: the predictor redirected fetch for this instruction.

Function
REQ-020 instr SHALL equal {rdata[7:0], rdata[15:8], rdata[23:16], rdata[31:24]}.
REQ-021 B SHALL be (instr[6:0] == 7'b1100011); J SHALL be (instr[6:0] == 7'b1101111).
REQ-022 The read index SHALL be pc_r[IDX_W+1:2]; the update index SHALL be upd_pc[IDX_W+1:2]; higher bits are ignored, so aliasing is accepted.
REQ-023 BrPre SHALL be B & ctr[read index][1]; pred SHALL be BrPre | J.
REQ-024 Branch target SHALL be pc_r + sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}); JAL target SHALL be pc_r + sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}); both mod 2^32.
REQ-025 Next PC priority: stall -> hold; else pc_sel -> pc_jump; else J -> JAL target; else BrPre -> branch target; else pc_r + 4 (wraps at 2^32).
REQ-026 IF/ID update on an unstalled edge: pc_if <= pc_r; pc_4_if <= pc_r + 4; instr_if <= pc_sel ? 0 : instr; BrPre_if <= pc_sel ? 0 : pred.
REQ-027 When stall is high, all IF/ID registers and pc_r SHALL hold; stall overrides pc_sel in the same cycle.
REQ-028 On upd_valid, the counter SHALL increment if upd_taken and decrement otherwise, saturating at 2'b11 and 2'b00.
REQ-029 Counter updates SHALL occur regardless of stall and pc_sel.
REQ-030 If the read index equals the update index in the same cycle, prediction SHALL use the pre-update value (no bypass).
REQ-031 Prediction latency: zero cycles (combinational from ICACHE_rdata); counter update visible to the next cycle's read.
REQ-032 The counter array SHALL use flops, not inferred RAM, so that all entries reset.

Reset
REQ-033 While rst is high: pc_r = RESET_PC; pc_if = pc_4_if = instr_if = 0; BrPre_if = 0; all counters = CTR_INIT.
REQ-034 Reset asserted mid-operation SHALL take effect immediately and asynchronously, discarding pending updates; the first fetch after deassertion SHALL be RESET_PC.

Verification
REQ-035 Reset, rdata = NOP 32'h13000000 (byte-swapped addi) -> ICACHE_addr 0, 1, 2 on successive cycles; BrPre_if = 0.
REQ-036 Reset, then 2 upd_valid/upd_taken=1 at upd_pc 0x40, then fetch a beq at 0x40 with offset +16 -> next pc_r = 0x50, BrPre_if = 1 one cycle later.
REQ-037 Counter saturation: 5 taken updates then 1 not-taken -> counter = 2'b10, still predicts taken; 3 more not-taken -> 2'b00, predicts not taken.
REQ-038 JAL at 0x100 with offset -8 and cold BHT -> next pc_r = 0xF8, BrPre_if = 1.
REQ-039 Simultaneous pc_sel = 1 (pc_jump 0x200) and predicted-taken branch -> pc_r = 0x200, instr_if = 0, BrPre_if = 0; with stall also high, everything holds.
REQ-040 ENTRIES = 4: updates at upd_pc 0x10 and 0x20 (aliasing) plus read/update same-index collision -> prediction uses the old counter value; reset asserted mid-sequence returns all counters to CTR_INIT.
